// File: rtl/fifo_rd_pkg.sv
// fifo_rd_packer shared types and defaults.
// Drain FSM states and default geometry.
package fifo_rd_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LANES_DEF = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    EMIT
  } state_t;

endpackage

// File: rtl/fifo_rd_out_slot.sv
// Single-entry valid/ready output register.
// Holds {data, keep, last} until the consumer accepts it.
module fifo_rd_out_slot #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          load_last,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic          m_last,
  output logic          free_next
);

  assign free_next = ~m_valid | m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side drain of the async FIFO: packs bytes
// into little-endian words with flush support.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                   r_clk,
  input  logic                   r_rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_r_en,
  input  logic [WIDTH-1:0]       fifo_d_out,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_last
);

  localparam int CW = $clog2(LANES + 1);
  localparam int DW = WIDTH * LANES;
  localparam logic [CW-1:0] FULL = CW'(LANES);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_cap;
  logic            pend_q;
  logic [DW-1:0]   asm_q;
  logic [DW-1:0]   asm_cap;
  logic [LANES-1:0] keep_cap;
  logic            xfer;
  logic            last_d;
  logic            done_d;
  logic            free_next;

  // cnt + pend counts bytes owned, including the one in flight
  assign cnt_cap = cnt_q + CW'(pend_q);

  assign fifo_r_en = r_rst_n & ~fifo_empty
                   & (state_q == RUN)
                   & (cnt_cap < FULL);

  always_comb begin
    asm_cap  = asm_q;
    keep_cap = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pend_q && (cnt_q == CW'(i)))
        asm_cap[i*WIDTH +: WIDTH] = fifo_d_out;
      keep_cap[i] = (CW'(i) < cnt_cap);
    end
  end

  // A full word arriving with flush is held for EMIT so it gets m_last
  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        if ((cnt_cap == FULL) && !flush && free_next)
          xfer = 1'b1;
        if (flush)
          state_d = DRAIN;
      end
      (state_q == DRAIN): begin
        if (!pend_q) begin
          if (cnt_q != '0) begin
            state_d = EMIT;
          end else begin
            done_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      (state_q == EMIT): begin
        if (free_next) begin
          xfer    = 1'b1;
          last_d  = 1'b1;
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      asm_q      <= '0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= fifo_r_en;
      flush_done <= done_d;
      if (xfer) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_cap;
        asm_q <= asm_cap;
      end
    end
  end

  fifo_rd_out_slot #(
    .DW(DW),
    .KW(LANES)
  ) u_slot (
    .clk       (r_clk),
    .rst_n     (r_rst_n),
    .load      (xfer),
    .load_data (asm_cap),
    .load_keep (keep_cap),
    .load_last (last_d),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .free_next (free_next)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO read model,
// vector table and hand-written flush/reset cases.
module tb_fifo_rd_packer;

  logic        r_clk = 1'b0;
  logic        r_rst_n = 1'b0;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [7:0]  fifo_d_out = 8'h00;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  logic [7:0]  mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        re_s = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          fd_cnt = 0;
  bit          rdy_mode = 1'b0;
  int          cyc = 0;
  logic [36:0] obs [$];
  logic        hold_v = 1'b0;
  logic [36:0] hold = '0;

  typedef struct {
    logic [31:0] din;
    int          nb;
    bit          fl;
    logic [36:0] exp;
  } vec_t;

  vec_t vt [6];

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_rd_packer #(.WIDTH(8), .LANES(4)) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_d_out (fifo_d_out),
    .flush      (flush),
    .flush_done (flush_done),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last)
  );

  always #5 r_clk = ~r_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge r_clk) begin
    #1;
    cyc = cyc + 1;
    m_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
  end

  always @(posedge r_clk) begin
    if (re_s) begin
      fifo_d_out <= mem[rd_ptr % 256];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(negedge r_clk) begin
    logic [36:0] cur;
    cur  = {m_last, m_keep, m_data};
    re_s <= fifo_r_en;
    if (fifo_r_en) begin
      n_tests++;
      if (fifo_empty) begin
        n_fail++;
        $display("FAIL r_en_vs_empty: r_en=1 while empty=1 (required 0)");
      end
    end
    if (hold_v) begin
      n_tests++;
      if (!m_valid || cur !== hold) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0b %h required v=1 %h",
                 m_valid, cur, hold);
      end
    end
    hold_v = r_rst_n && m_valid && !m_ready;
    hold   = cur;
    if (r_rst_n && m_valid && m_ready)
      obs.push_back(cur);
    if (flush_done)
      fd_cnt++;
  end

  task automatic chk(input string nm, input logic [36:0] act,
                     input logic [36:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic get_word(input string nm, input logic [36:0] exp);
    logic [36:0] w;
    bit ok;
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge r_clk);
      if (obs.size() > 0) begin
        w  = obs.pop_front();
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no word within bound, required %h", nm, exp);
    end else begin
      chk(nm, w, exp);
    end
  endtask

  initial begin
    int fd0;
    logic [31:0] d;

    vt[0] = '{32'h04030201, 4, 1'b0, {1'b0, 4'hF, 32'h04030201}};
    vt[1] = '{32'h08070605, 4, 1'b0, {1'b0, 4'hF, 32'h08070605}};
    vt[2] = '{32'h04030201, 4, 1'b0, {1'b0, 4'hF, 32'h04030201}};
    vt[3] = '{32'h00000605, 2, 1'b1, {1'b1, 4'h3, 32'h00000605}};
    vt[4] = '{32'h0000005A, 1, 1'b1, {1'b1, 4'h1, 32'h0000005A}};
    vt[5] = '{32'h00C3B2A1, 3, 1'b1, {1'b1, 4'h7, 32'h00C3B2A1}};

    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    chk("rst_m_valid", 37'(m_valid), 37'(0));
    chk("rst_m_data", 37'(m_data), 37'(0));
    chk("rst_m_keep", 37'(m_keep), 37'(0));
    chk("rst_m_last", 37'(m_last), 37'(0));
    chk("rst_flush_done", 37'(flush_done), 37'(0));
    chk("rst_r_en", 37'(fifo_r_en), 37'(0));
    @(posedge r_clk);
    #1 r_rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      fd0 = fd_cnt;
      d = vt[i].din;
      for (int j = 0; j < vt[i].nb; j++)
        push(d[j*8 +: 8]);
      if (vt[i].fl) begin
        tick(8);
        pulse_flush();
      end
      get_word($sformatf("vec%0d_word", i), vt[i].exp);
      tick(4);
      chk($sformatf("vec%0d_flush_done", i),
          37'(fd_cnt - fd0), 37'(vt[i].fl));
    end

    tick(4);
    fd0 = fd_cnt;
    pulse_flush();
    @(negedge r_clk);
    chk("eflush_fd_c1", 37'(flush_done), 37'(0));
    @(negedge r_clk);
    chk("eflush_fd_c2", 37'(flush_done), 37'(1));
    @(negedge r_clk);
    chk("eflush_fd_c3", 37'(flush_done), 37'(0));
    tick(6);
    chk("eflush_no_word", 37'(obs.size()), 37'(0));
    chk("eflush_fd_once", 37'(fd_cnt - fd0), 37'(1));

    rdy_mode = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++)
      push(8'(8'h40 + i));
    get_word("bp_w0", {1'b0, 4'hF, 32'h43424140});
    get_word("bp_w1", {1'b0, 4'hF, 32'h47464544});
    get_word("bp_w2", {1'b0, 4'hF, 32'h4B4A4948});
    get_word("bp_w3", {1'b0, 4'hF, 32'h4F4E4D4C});
    tick(6);
    rdy_mode = 1'b0;
    tick(4);

    fd0 = fd_cnt;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick(8);
    push(8'h34);
    tick(1);
    pulse_flush();
    get_word("pend_flush_word", {1'b1, 4'hF, 32'h34333231});
    tick(4);
    chk("pend_flush_fd", 37'(fd_cnt - fd0), 37'(1));
    chk("pend_flush_single", 37'(obs.size()), 37'(0));

    push(8'h11);
    push(8'h22);
    tick(8);
    r_rst_n = 1'b0;
    push(8'hA0);
    @(negedge r_clk);
    chk("rst_mid_r_en", 37'(fifo_r_en), 37'(0));
    tick(1);
    r_rst_n = 1'b1;
    @(negedge r_clk);
    chk("rst_mid_m_valid", 37'(m_valid), 37'(0));
    tick(1);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    get_word("rst_mid_word", {1'b0, 4'hF, 32'hA3A2A1A0});

    tick(10);
    chk("no_extra_words", 37'(obs.size()), 37'(0));
    chk("fifo_drained", 37'(wr_ptr - rd_ptr), 37'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
